// File: rtl/tile_frame_buffer_db_if.sv
// Tile write port of the double-buffered tile map: valid/ready request plus a
// one-cycle error pulse for writes whose coordinates fall outside the map.
interface tile_frame_buffer_db_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic       wr_data;
    logic       wr_err;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/tile_frame_buffer_db.sv
// Double-buffered tile map: writes/clears go to the back buffer, swaps happen only on
// frame_start, and the front buffer is expanded into a full pixel row for the row driver.
module tile_frame_buffer_db #(
    parameter int COLS         = 14,
    parameter int ROWS         = 8,
    parameter int TILE_W       = 120,
    parameter int TILE_H       = 60,
    parameter int PAD          = 8,
    parameter int ROW_BITS     = 9,
    parameter bit INIT_FILL    = 1'b1,
    parameter bit COPY_ON_SWAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    tile_frame_buffer_db_if.slave          wr,
    input  logic                           clear_req,
    input  logic                           clear_val,
    input  logic                           swap_req,
    input  logic                           frame_start,
    output logic                           swap_done,
    output logic                           busy,
    output logic                           front_sel,
    input  logic [ROW_BITS-1:0]            pix_row,
    output logic [2*PAD+COLS*TILE_W-1:0]   row_data
);

    localparam int W  = 2*PAD + COLS*TILE_W;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COPY} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic              clear_val_q, clear_val_d;
    logic              front_sel_q, front_sel_d;
    logic              pending_q, pending_d;
    logic              wr_ready_q, wr_ready_d;
    logic              wr_err_q, wr_err_d;
    logic              swap_done_q, swap_done_d;
    logic              busy_q, busy_d;
    logic [W-1:0]      row_data_q, row_data_d;

    // Each buffer row holds one tile per bit, bit c = column c.
    logic [COLS-1:0]   mem_q [0:1][0:ROWS-1];
    logic [COLS-1:0]   mem_d [0:1][0:ROWS-1];

    logic              accept, in_range, fire, back_sel, row_vld;
    logic [RW-1:0]     tile_row;
    logic [COLS-1:0]   sel_row;

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        clear_val_d = clear_val_q;
        mem_d       = mem_q;

        accept   = wr.wr_valid & wr_ready_q;
        in_range = (wr.wr_x < 8'(COLS)) && (wr.wr_y < 8'(ROWS));
        back_sel = ~front_sel_q;
        fire     = frame_start & (pending_q | swap_req) & (state_q == S_IDLE);

        // The write lands in the pre-swap back buffer, i.e. the new front after a swap.
        if (accept && in_range) begin
            mem_d[back_sel][wr.wr_y[RW-1:0]][wr.wr_x[CW-1:0]] = wr.wr_data;
        end
        wr_err_d    = accept & ~in_range;
        pending_d   = fire ? 1'b0 : (pending_q | swap_req);
        front_sel_d = front_sel_q ^ fire;
        swap_done_d = fire;

        case (state_q)
            S_IDLE: begin
                // A clear overwrites the whole back buffer, so it takes precedence over
                // a copy-on-swap that would start on the same edge.
                if (clear_req) begin
                    state_d     = S_CLEAR;
                    row_cnt_d   = '0;
                    clear_val_d = clear_val;
                end else if (fire && COPY_ON_SWAP) begin
                    state_d   = S_COPY;
                    row_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                mem_d[back_sel][row_cnt_q] = {COLS{clear_val_q}};
                row_cnt_d = row_cnt_q + RW'(1);
                if (row_cnt_q == RW'(ROWS-1)) state_d = S_IDLE;
            end
            S_COPY: begin
                mem_d[back_sel][row_cnt_q] = mem_q[front_sel_q][row_cnt_q];
                row_cnt_d = row_cnt_q + RW'(1);
                if (row_cnt_q == RW'(ROWS-1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wr_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);

        // Display reads the post-edge front buffer so same-edge swaps and writes show at once.
        row_vld  = pix_row < ROW_BITS'(ROWS*TILE_H);
        tile_row = RW'(pix_row / ROW_BITS'(TILE_H));
        sel_row  = row_vld ? mem_d[front_sel_d][tile_row] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign row_data_d[W-1-PAD-gi*TILE_W -: TILE_W] = {TILE_W{sel_row[gi]}};
        end
    endgenerate
    assign row_data_d[W-1 -: PAD] = '0;
    assign row_data_d[PAD-1:0]    = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            clear_val_q <= 1'b0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            wr_ready_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            swap_done_q <= 1'b0;
            busy_q      <= 1'b0;
            row_data_q  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[b][r] <= {COLS{INIT_FILL}};
                end
            end
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            clear_val_q <= clear_val_d;
            front_sel_q <= front_sel_d;
            pending_q   <= pending_d;
            wr_ready_q  <= wr_ready_d;
            wr_err_q    <= wr_err_d;
            swap_done_q <= swap_done_d;
            busy_q      <= busy_d;
            row_data_q  <= row_data_d;
            mem_q       <= mem_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign wr.wr_err   = wr_err_q;
    assign swap_done   = swap_done_q;
    assign busy        = busy_q;
    assign front_sel   = front_sel_q;
    assign row_data    = row_data_q;

endmodule
